// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions: opcode constants, hazard FSM state encoding
// and the "instruction reads rt" decode helper.
package hazard_control_unit_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SW       = 6'h2B;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MUL_WAIT   = 2'd2
    } hcu_state_e;

    // For every other opcode, rt is a destination or immediate-class field.
    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
               (opcode == OP_SB)    || (opcode == OP_SH)  || (opcode == OP_SW)  ||
               (opcode == OP_SPECIAL2);
    endfunction

endpackage

// File: rtl/hazard_control_unit_load_use_detect.sv
// Combinational load-use detector: a load in EX whose destination is read
// by the instruction currently in ID.
module load_use_detect
    import hazard_control_unit_pkg::*;
(
    input  logic [15:0] id_instr_hi,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    output logic        load_use
);

    logic [5:0] id_opcode;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       rs_hit;
    logic       rt_hit;

    assign id_opcode = id_instr_hi[15:10];
    assign id_rs     = id_instr_hi[9:5];
    assign id_rt     = id_instr_hi[4:0];

    assign rs_hit   = (ex_rt == id_rs);
    assign rt_hit   = (ex_rt == id_rt) && uses_rt(id_opcode);
    // $zero never carries a real dependency.
    assign load_use = ex_mem_read && (ex_rt != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes,
// multi-cycle madd/msub freeze, and a stall-cycle counter.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 3
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] IDInstruction,
    input  logic        EXMemRead,
    input  logic [4:0]  EXRt,
    input  logic        EXMaddMsub,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXWrite,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        EXMEMFlush,
    output logic        Busy,
    output logic [15:0] StallCount
);

    localparam int CW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [CW-1:0] MUL_RELOAD = CW'(MULT_CYCLES - 2);

    hcu_state_e    state_q, state_d;
    logic [CW-1:0] mul_cnt_q, mul_cnt_d;
    logic [15:0]   stall_count_q, stall_count_d;
    logic          load_use;
    logic          unused_imm_bits;

    // Only opcode/rs/rt take part in hazard detection.
    assign unused_imm_bits = ^IDInstruction[15:0];

    load_use_detect u_load_use_detect (
        .id_instr_hi (IDInstruction[31:16]),
        .ex_mem_read (EXMemRead),
        .ex_rt       (EXRt),
        .load_use    (load_use)
    );

    always_comb begin
        state_d    = state_q;
        mul_cnt_d  = mul_cnt_q;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        Busy       = 1'b0;

        case (state_q)
            RUN: begin
                if (EXMaddMsub) begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXWrite  = 1'b0;
                    EXMEMFlush = 1'b1;
                    Busy       = 1'b1;
                    mul_cnt_d  = MUL_RELOAD;
                    state_d    = MUL_WAIT;
                end else if (BranchTaken) begin
                    // A load-use against a wrong-path instruction is moot.
                    IFIDFlush = 1'b1;
                    IDEXFlush = 1'b1;
                end else if (load_use) begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEXFlush = 1'b1;
                    state_d   = LOAD_STALL;
                end
            end
            LOAD_STALL: begin
                state_d = RUN;
            end
            MUL_WAIT: begin
                Busy = 1'b1;
                if (mul_cnt_q != '0) begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXWrite  = 1'b0;
                    EXMEMFlush = 1'b1;
                    mul_cnt_d  = mul_cnt_q - CW'(1);
                end else begin
                    // Release cycle: the multiply result commits to EX/MEM here.
                    state_d = RUN;
                end
            end
            default: begin
                state_d   = RUN;
                mul_cnt_d = '0;
            end
        endcase

        if (Rst) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
            Busy       = 1'b0;
        end
    end

    assign stall_count_d = PCWrite ? stall_count_q : stall_count_q + 16'd1;
    assign StallCount    = stall_count_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q       <= RUN;
            mul_cnt_q     <= '0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            mul_cnt_q     <= mul_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit; a second instance with a long
// multiply latency exercises the StallCount wrap in reasonable time.
module tb_hazard_control_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] IDInstruction;
    logic        EXMemRead;
    logic [4:0]  EXRt;
    logic        EXMaddMsub;
    logic        BranchTaken;
    logic        PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush, Busy;
    logic [15:0] StallCount;

    logic        w_rst;
    logic        w_madd;
    logic        w_pcw, w_ifw, w_idw, w_iff, w_idf, w_exf, w_busy;
    logic [15:0] w_count;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush, Busy}
    localparam logic [6:0] C_DEF = 7'b111_000_0;
    localparam logic [6:0] C_RST = 7'b000_111_0;
    localparam logic [6:0] C_LU  = 7'b001_010_0;
    localparam logic [6:0] C_BR  = 7'b111_110_0;
    localparam logic [6:0] C_FRZ = 7'b000_001_1;
    localparam logic [6:0] C_REL = 7'b111_000_1;

    localparam logic [31:0] I_ADD  = 32'h0101_4820; // add  $9,$8,$1
    localparam logic [31:0] I_ADDI = 32'h2048_0005; // addi $8,$2,5
    localparam logic [31:0] I_SW   = 32'hAC48_0000; // sw   $8,0($2)
    localparam logic [31:0] I_NOP  = 32'h0000_0000;

    logic [6:0] ctl;
    assign ctl = {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush, Busy};

    always #5 Clk = ~Clk;

    hazard_control_unit #(.MULT_CYCLES(3)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .IDInstruction (IDInstruction),
        .EXMemRead     (EXMemRead),
        .EXRt          (EXRt),
        .EXMaddMsub    (EXMaddMsub),
        .BranchTaken   (BranchTaken),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .IDEXWrite     (IDEXWrite),
        .IFIDFlush     (IFIDFlush),
        .IDEXFlush     (IDEXFlush),
        .EXMEMFlush    (EXMEMFlush),
        .Busy          (Busy),
        .StallCount    (StallCount)
    );

    hazard_control_unit #(.MULT_CYCLES(16)) dut_wrap (
        .Clk           (Clk),
        .Rst           (w_rst),
        .IDInstruction (32'h0000_0000),
        .EXMemRead     (1'b0),
        .EXRt          (5'd0),
        .EXMaddMsub    (w_madd),
        .BranchTaken   (1'b0),
        .PCWrite       (w_pcw),
        .IFIDWrite     (w_ifw),
        .IDEXWrite     (w_idw),
        .IFIDFlush     (w_iff),
        .IDEXFlush     (w_idf),
        .EXMEMFlush    (w_exf),
        .Busy          (w_busy),
        .StallCount    (w_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge, return at the falling edge.
    task automatic step(input logic [31:0] ins, input logic mr, input logic [4:0] rt,
                        input logic mm, input logic br);
        @(posedge Clk);
        #1;
        IDInstruction = ins;
        EXMemRead     = mr;
        EXRt          = rt;
        EXMaddMsub    = mm;
        BranchTaken   = br;
        @(negedge Clk);
    endtask

    initial begin
        Rst = 1'b1; w_rst = 1'b1; w_madd = 1'b0;
        IDInstruction = I_NOP; EXMemRead = 1'b0; EXRt = 5'd0;
        EXMaddMsub = 1'b0; BranchTaken = 1'b0;

        @(negedge Clk);
        check_eq("reset_ctl", 32'(ctl), 32'(C_RST));
        check_eq("reset_cnt", 32'(StallCount), 32'h0);

        @(posedge Clk); #1; Rst = 1'b0; @(negedge Clk);
        check_eq("idle_ctl", 32'(ctl), 32'(C_DEF));

        // Load-use: one bubble, then defaults
        step(I_ADD, 1'b1, 5'd8, 1'b0, 1'b0);
        check_eq("lu_ctl", 32'(ctl), 32'(C_LU));
        check_eq("lu_cnt0", 32'(StallCount), 32'd0);
        step(I_ADD, 1'b1, 5'd8, 1'b0, 1'b0);
        check_eq("lu_stall_ctl", 32'(ctl), 32'(C_DEF));
        check_eq("lu_cnt1", 32'(StallCount), 32'd1);
        step(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
        check_eq("lu_after_ctl", 32'(ctl), 32'(C_DEF));

        // No-stall cases and an rt-source store
        step(I_NOP, 1'b1, 5'd0, 1'b0, 1'b0);
        check_eq("rt0_ctl", 32'(ctl), 32'(C_DEF));
        step(I_ADDI, 1'b1, 5'd8, 1'b0, 1'b0);
        check_eq("addi_ctl", 32'(ctl), 32'(C_DEF));
        step(I_SW, 1'b1, 5'd8, 1'b0, 1'b0);
        check_eq("sw_rt_ctl", 32'(ctl), 32'(C_LU));
        step(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
        check_eq("sw_after_cnt", 32'(StallCount), 32'd2);

        // Branch beats load-use; next cycle still in RUN so load-use fires
        step(I_ADD, 1'b1, 5'd8, 1'b0, 1'b1);
        check_eq("br_lu_ctl", 32'(ctl), 32'(C_BR));
        check_eq("br_lu_cnt", 32'(StallCount), 32'd2);
        step(I_ADD, 1'b1, 5'd8, 1'b0, 1'b0);
        check_eq("br_then_lu_ctl", 32'(ctl), 32'(C_LU));
        step(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
        check_eq("br_then_lu_cnt", 32'(StallCount), 32'd3);

        // Multiply: two freeze cycles then a release; branch in MUL_WAIT ignored
        step(I_NOP, 1'b0, 5'd0, 1'b1, 1'b0);
        check_eq("mul_frz1_ctl", 32'(ctl), 32'(C_FRZ));
        step(I_NOP, 1'b0, 5'd0, 1'b1, 1'b1);
        check_eq("mul_frz2_ctl", 32'(ctl), 32'(C_FRZ));
        step(I_NOP, 1'b0, 5'd0, 1'b1, 1'b1);
        check_eq("mul_rel_ctl", 32'(ctl), 32'(C_REL));
        check_eq("mul_rel_cnt", 32'(StallCount), 32'd5);
        step(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
        check_eq("mul_done_ctl", 32'(ctl), 32'(C_DEF));
        check_eq("mul_done_cnt", 32'(StallCount), 32'd5);

        // Reset during the second MUL_WAIT cycle
        step(I_NOP, 1'b0, 5'd0, 1'b1, 1'b0);
        check_eq("mrst_frz1_ctl", 32'(ctl), 32'(C_FRZ));
        step(I_NOP, 1'b0, 5'd0, 1'b1, 1'b0);
        check_eq("mrst_frz2_ctl", 32'(ctl), 32'(C_FRZ));
        @(posedge Clk); #1; Rst = 1'b1; @(negedge Clk);
        check_eq("mrst_ctl", 32'(ctl), 32'(C_RST));
        check_eq("mrst_cnt", 32'(StallCount), 32'd0);
        @(posedge Clk); #1; Rst = 1'b0; EXMaddMsub = 1'b0; @(negedge Clk);
        check_eq("mrst_after_ctl", 32'(ctl), 32'(C_DEF));
        check_eq("mrst_after_cnt", 32'(StallCount), 32'd0);

        // Wrap: MULT_CYCLES=16 gives 15 stalls per 16 cycles; 4369 periods = 65535 stalls
        @(posedge Clk); #1; w_rst = 1'b0; w_madd = 1'b1;
        repeat (69904) @(posedge Clk);
        @(negedge Clk);
        check_eq("wrap_ffff", 32'(w_count), 32'h0000_FFFF);
        @(negedge Clk);
        check_eq("wrap_zero", 32'(w_count), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
